uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single UART transmitter between `NUM_REQ` byte producers. Each requester presents a byte with a valid/ready handshake. The block grants one requester at a time, drives `TX_data`/`TX_start` into the transmitter, and tracks `TX_busy` until the frame completes before serving the next requester. It runs on the transmitter's clock (`baud_clk` at the UART top level) and sits between the producers and the transmitter.

---
 rtl/uart_ctrl_pkg.sv | 12 +
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 98 +++++++++
 tb/tb_uart_tx_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and data width.
package uart_ctrl_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake and transmitter-facing signals of the UART transmit arbiter.
interface uart_tx_arbiter_if
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [UART_DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [UART_DATA_W-1:0]         TX_data;
  logic                           TX_start;
  logic                           TX_busy;

  modport master (
    output req_valid, req_data, TX_busy,
    input  req_ready, TX_data, TX_start
  );

  modport slave (
    input  req_valid, req_data, TX_busy,
    output req_ready, TX_data, TX_start
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotating-priority pick: first valid requester at or above rr_ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_valid && req_valid[idx]) begin
        any_valid  = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
//
// state | meaning
// IDLE  | no frame in flight; grant cycle when TX_busy=0 and a requester is valid
// START | TX_start held, waiting for TX_busy to rise or the start timeout
// DONE  | frame accepted by the transmitter, waiting for TX_busy to fall
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16,
  parameter int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic              CLK,
  input  logic              RST,
  uart_tx_arbiter_if.slave  bus,
  output logic [IDX_W-1:0]  grant_id,
  output logic              active,
  output logic              timeout_err
);

  localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(START_TIMEOUT - 1);

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       tmo_cnt;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [IDX_W-1:0]       ptr_next;
  logic [UART_DATA_W-1:0] pick_data;
  logic                   grant_now;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_onehot),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  assign ptr_next  = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign pick_data = bus.req_data[int'(pick_idx)*UART_DATA_W +: UART_DATA_W];
  assign grant_now = (state == IDLE) && !bus.TX_busy && pick_any;

  // Gated by RST so a reset asserted mid-cycle clears ready without an edge.
  assign bus.req_ready = (grant_now && !RST) ? pick_onehot : '0;
  assign active        = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      tmo_cnt      <= '0;
      grant_id     <= '0;
      timeout_err  <= 1'b0;
      bus.TX_data  <= '0;
      bus.TX_start <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_now) begin
            bus.TX_data  <= pick_data;
            grant_id     <= pick_idx;
            rr_ptr       <= ptr_next;
            tmo_cnt      <= CNT_LOAD;
            bus.TX_start <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          if (bus.TX_busy) begin
            bus.TX_start <= 1'b0;
            tmo_cnt      <= '0;
            state        <= DONE;
          end else if (tmo_cnt == '0) begin
            // Byte is dropped; rr_ptr already moved past this requester.
            bus.TX_start <= 1'b0;
            timeout_err  <= 1'b1;
            state        <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        DONE: begin
          if (!bus.TX_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle behavioural model plus directed literal checks.
module tb_uart_tx_arbiter;
  import uart_ctrl_pkg::*;

  localparam int N = 4;
  localparam int T = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] grant_id;
  logic       active;
  logic       timeout_err;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(T)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (((v >> idx) & 4'b0001) == 4'b0001) return idx;
    end
    return -1;
  endfunction

  // Transmitter stand-in: raises busy rise_dly cycles after seeing TX_start, holds it busy_len cycles.
  bit auto_tx     = 1'b1;
  bit busy_manual = 1'b0;
  int rise_dly    = 2;
  int busy_len    = 3;
  int tx_cnt      = 0;

  always @(posedge CLK) begin
    #1;
    if (RST) begin
      bus.TX_busy = 1'b0;
      tx_cnt      = 0;
    end else if (!auto_tx) begin
      bus.TX_busy = busy_manual;
      tx_cnt      = 0;
    end else if (!bus.TX_busy) begin
      if (bus.TX_start) begin
        tx_cnt++;
        if (tx_cnt >= rise_dly) begin
          bus.TX_busy = 1'b1;
          tx_cnt      = 0;
        end
      end else begin
        tx_cnt = 0;
      end
    end else begin
      tx_cnt++;
      if (tx_cnt >= busy_len) begin
        bus.TX_busy = 1'b0;
        tx_cnt      = 0;
      end
    end
  end

  // Behavioural model: a frame is "in flight" from grant until the transmitter finishes or the start times out.
  bit       m_in, m_start, m_err;
  bit [7:0] m_data;
  int       m_gid, m_ptr, m_age, m_pick;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_in = 0; m_start = 0; m_err = 0; m_data = 8'h00; m_gid = 0; m_ptr = 0; m_age = 0;
    end else begin
      m_err  = 0;
      m_pick = pick(m_ptr, bus.req_valid);
      if (!m_in) begin
        if (bus.TX_busy === 1'b0 && m_pick >= 0) begin
          m_data  = bus.req_data[m_pick*8 +: 8];
          m_gid   = m_pick;
          m_ptr   = (m_pick + 1) % N;
          m_in    = 1;
          m_start = 1;
          m_age   = 1;
        end
      end else if (m_start) begin
        if (bus.TX_busy) m_start = 0;
        else if (m_age == T) begin
          m_start = 0;
          m_in    = 0;
          m_err   = 1;
        end else m_age++;
      end else if (!bus.TX_busy) begin
        m_in = 0;
      end
    end
  end

  logic [N-1:0] exp_rdy;
  int           c_pick;

  always @(negedge CLK) begin
    if (!RST) begin
      c_pick  = pick(m_ptr, bus.req_valid);
      exp_rdy = (!m_in && bus.TX_busy === 1'b0 && c_pick >= 0) ? N'(1 << c_pick) : '0;
      chk("m_req_ready",   32'(bus.req_ready), 32'(exp_rdy));
      chk("m_tx_start",    32'(bus.TX_start),  32'(m_start));
      chk("m_tx_data",     32'(bus.TX_data),   32'(m_data));
      chk("m_grant_id",    32'(grant_id),      32'(m_gid));
      chk("m_active",      32'(active),        32'(m_in));
      chk("m_timeout_err", 32'(timeout_err),   32'(m_err));
    end
  end

  // Observation of DUT outputs for directed literal checks.
  logic [7:0] cap[$];
  int         rdy_cnt[N];
  int         run_len = 0;
  int         last_run = 0;
  logic       prev_start = 1'b0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.TX_start && !prev_start) cap.push_back(bus.TX_data);
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) rdy_cnt[i]++;
      if (bus.TX_start) run_len++;
      else if (run_len > 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      prev_start = bus.TX_start;
    end else begin
      prev_start = 1'b0;
      run_len    = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    cap.delete();
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (active !== 1'b0 && k < 200) begin
      tick(1);
      k++;
    end
    #1;
    chk(nm, 32'(active), 32'd0);
  endtask

  task automatic wait_caps(input int n, input string nm);
    int k = 0;
    while (cap.size() < n && k < 300) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(cap.size()), 32'(n));
  endtask

  logic [7:0] exp_rr[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
  logic [7:0] exp_pf[3] = '{8'h22, 8'h33, 8'h22};

  initial begin
    int k;
    bus.req_valid = '0;
    bus.req_data  = '0;
    tick(3);
    RST = 1'b0;
    #1;
    chk("rst_tx_start",    32'(bus.TX_start),  32'd0);
    chk("rst_tx_data",     32'(bus.TX_data),   32'd0);
    chk("rst_grant_id",    32'(grant_id),      32'd0);
    chk("rst_active",      32'(active),        32'd0);
    chk("rst_timeout_err", 32'(timeout_err),   32'd0);
    chk("rst_req_ready",   32'(bus.req_ready), 32'd0);

    // Single byte from requester 1
    tick(1);
    bus.req_data  = 32'h0000_A500;
    bus.req_valid = 4'b0010;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h2);
    tick(1);
    bus.req_valid = '0;
    #1;
    chk("single_start",  32'(bus.TX_start), 32'd1);
    chk("single_data",   32'(bus.TX_data),  32'hA5);
    chk("single_gid",    32'(grant_id),     32'd1);
    chk("single_ready0", 32'(bus.req_ready), 32'd0);
    tick(1); #1;
    chk("single_start_e2", 32'(bus.TX_start), 32'd1);
    tick(1); #1;
    chk("single_start_fall", 32'(bus.TX_start), 32'd0);
    chk("single_active_done", 32'(active), 32'd1);
    tick(2); #1;
    chk("single_active_e5", 32'(active), 32'd1);
    tick(1); #1;
    chk("single_active_off", 32'(active), 32'd0);

    // Round-robin with all requesters continuously valid
    tick(1);
    do_reset();
    bus.req_data  = 32'h1312_1110;
    bus.req_valid = 4'b1111;
    wait_caps(5, "rr_cap_count");
    bus.req_valid = '0;
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_byte%0d", i), (i < cap.size()) ? 32'(cap[i]) : 32'hFFF, 32'(exp_rr[i]));
    chk("rr_ready0", 32'(rdy_cnt[0]), 32'd2);
    chk("rr_ready1", 32'(rdy_cnt[1]), 32'd1);
    chk("rr_ready2", 32'(rdy_cnt[2]), 32'd1);
    chk("rr_ready3", 32'(rdy_cnt[3]), 32'd1);
    wait_idle("rr_idle");

    // Pointer fairness after serving requester 2
    tick(1);
    do_reset();
    bus.req_data  = 32'h3322_0000;
    bus.req_valid = 4'b0100;
    wait_caps(1, "pf_first");
    bus.req_valid = '0;
    wait_idle("pf_idle1");
    tick(1);
    bus.req_valid = 4'b1100;
    wait_caps(3, "pf_cap_count");
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++)
      chk($sformatf("pf_byte%0d", i), (i < cap.size()) ? 32'(cap[i]) : 32'hFFF, 32'(exp_pf[i]));
    wait_idle("pf_idle2");

    // Start timeout with TX_busy stuck low
    tick(1);
    do_reset();
    auto_tx       = 1'b0;
    busy_manual   = 1'b0;
    bus.req_data  = 32'h0000_5544;
    bus.req_valid = 4'b0011;
    tick(1);
    bus.req_valid = 4'b0010;
    #1;
    chk("tmo_gid0", 32'(grant_id), 32'd0);
    k = 0;
    while (timeout_err !== 1'b1 && k < 40) begin
      tick(1);
      #1;
      k++;
    end
    chk("tmo_err_seen", 32'(timeout_err), 32'd1);
    chk("tmo_active",   32'(active),      32'd0);
    chk("tmo_regrant",  32'(bus.req_ready), 32'h2);
    #3;
    chk("tmo_start_len", 32'(last_run), 32'(T));
    tick(1);
    bus.req_valid = '0;
    auto_tx       = 1'b1;
    #1;
    chk("tmo_next_start", 32'(bus.TX_start), 32'd1);
    chk("tmo_next_data",  32'(bus.TX_data),  32'h55);
    chk("tmo_next_gid",   32'(grant_id),     32'd1);
    chk("tmo_err_clear",  32'(timeout_err),  32'd0);
    wait_idle("tmo_idle");

    // Asynchronous reset while in DONE
    tick(1);
    do_reset();
    busy_len      = 10;
    bus.req_data  = 32'h9900_0077;
    bus.req_valid = 4'b0001;
    k = 0;
    while (!(active === 1'b1 && bus.TX_start === 1'b0) && k < 40) begin
      tick(1);
      bus.req_valid = '0;
      #1;
      k++;
    end
    chk("rd_in_done", 32'(active), 32'd1);
    tick(1);
    bus.req_valid = 4'b1001;
    RST = 1'b1;
    #1;
    chk("rd_start0",  32'(bus.TX_start),  32'd0);
    chk("rd_active0", 32'(active),        32'd0);
    chk("rd_ready0",  32'(bus.req_ready), 32'd0);
    tick(2);
    RST = 1'b0;
    busy_len = 3;
    #1;
    chk("rd_ready_after", 32'(bus.req_ready), 32'h1);
    tick(1);
    bus.req_valid = '0;
    #1;
    chk("rd_gid",  32'(grant_id),    32'd0);
    chk("rd_data", 32'(bus.TX_data), 32'h77);
    wait_idle("rd_idle");

    // Busy hold-off in IDLE
    tick(1);
    auto_tx     = 1'b0;
    busy_manual = 1'b1;
    tick(2);
    bus.req_data  = 32'h0000_0066;
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ho_ready_held", 32'(bus.req_ready), 32'd0);
      chk("ho_active_held", 32'(active), 32'd0);
      tick(1);
    end
    busy_manual = 1'b0;
    tick(1);
    #1;
    chk("ho_ready_release", 32'(bus.req_ready), 32'h1);
    tick(1);
    bus.req_valid = '0;
    auto_tx       = 1'b1;
    #1;
    chk("ho_start", 32'(bus.TX_start), 32'd1);
    chk("ho_data",  32'(bus.TX_data),  32'h66);
    wait_idle("ho_idle");

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
